// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, controller states and the control-word layout.
// Imported by the controller, the ALU and the instruction-register consumer.
package cpu_defs;

  typedef enum logic [2:0] {
    OP_HLT  = 3'b000,
    OP_SKZ  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ANDD = 3'b011,
    OP_XORR = 3'b100,
    OP_LDA  = 3'b101,
    OP_STO  = 3'b110,
    OP_JMP  = 3'b111
  } opcode_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  // Control word, MSB first, in the same order as the controller's output ports.
  typedef struct packed {
    logic load_ir;
    logic rd;
    logic wr;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  // Instructions that fetch an operand from memory into the accumulator path.
  function automatic logic is_mem_read_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational control decode: maps the state being entered plus the current
// opcode and zero flag to the eight control signals.
module ctl_decode
  import cpu_defs::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    zero,
  output ctl_t    ctl
);

  logic mem_op;
  logic skz_taken;

  always_comb begin
    ctl       = '0;
    mem_op    = is_mem_read_op(opcode);
    skz_taken = (opcode == OP_SKZ) && zero;

    case (state)
      ST_S0, ST_S1: begin
        ctl.load_ir = 1'b1;
        ctl.rd      = 1'b1;
        ctl.inc_pc  = 1'b1;
      end
      ST_S3: begin
        ctl.halt = (opcode == OP_HLT);
      end
      ST_S4: begin
        ctl.rd          = mem_op;
        ctl.datactl_ena = (opcode == OP_STO);
        ctl.load_pc     = (opcode == OP_JMP);
      end
      ST_S5: begin
        ctl.rd          = mem_op;
        ctl.load_acc    = mem_op;
        ctl.wr          = (opcode == OP_STO);
        ctl.datactl_ena = (opcode == OP_STO);
        ctl.load_pc     = (opcode == OP_JMP);
        ctl.inc_pc      = skz_taken;
      end
      ST_S6: begin
        ctl.rd          = mem_op;
        ctl.datactl_ena = (opcode == OP_STO);
      end
      ST_S7: begin
        ctl.inc_pc = skz_taken;
      end
      ST_HALTED: begin
        ctl.halt = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction-sequencing controller: IDLE -> S0..S7 per instruction, HALTED on HLT.
// Outputs are registered so they are valid for the whole cycle spent in each state.
module cpu_controller
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt
);

  state_t  state_q, state_d;
  ctl_t    ctl_q, ctl_d;
  opcode_t op;

  assign op = opcode_t'(opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ena ? ST_S0 : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default: begin
        if (!ena) begin
          state_d = ST_IDLE;
        end else begin
          case (state_q)
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = (op == OP_HLT) ? ST_HALTED : ST_S4;
            ST_S4:   state_d = ST_S5;
            ST_S5:   state_d = ST_S6;
            ST_S6:   state_d = ST_S7;
            ST_S7:   state_d = ST_S0;
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // Decoding the state being entered lets the register hold that state's outputs.
  ctl_decode u_ctl_decode (
    .state  (state_d),
    .opcode (op),
    .zero   (zero),
    .ctl    (ctl_d)
  );

  assign load_ir     = ctl_q.load_ir;
  assign rd          = ctl_q.rd;
  assign wr          = ctl_q.wr;
  assign inc_pc      = ctl_q.inc_pc;
  assign load_pc     = ctl_q.load_pc;
  assign load_acc    = ctl_q.load_acc;
  assign datactl_ena = ctl_q.datactl_ena;
  assign halt        = ctl_q.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: expected control words are queued as each
// cycle's stimulus is applied and popped for comparison after the clock edge.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;

  cpu_controller dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .load_ir     (load_ir),
    .rd          (rd),
    .wr          (wr),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: load_ir rd wr inc_pc load_pc load_acc datactl_ena halt
  localparam logic [7:0] Z     = 8'b0000_0000;
  localparam logic [7:0] FETCH = 8'b1101_0000;
  localparam logic [7:0] RD    = 8'b0100_0000;
  localparam logic [7:0] RDACC = 8'b0100_0100;
  localparam logic [7:0] DE    = 8'b0000_0010;
  localparam logic [7:0] WRDE  = 8'b0010_0010;
  localparam logic [7:0] LPC   = 8'b0000_1000;
  localparam logic [7:0] INC   = 8'b0001_0000;
  localparam logic [7:0] HLTW  = 8'b0000_0001;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, LDA = 3'b101,
                         STO = 3'b110, JMP = 3'b111;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned inc_cnt = 0;

  function automatic logic [7:0] observed();
    return {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: queue the expectation, clock, then compare the word the DUT produced.
  task automatic cyc(input logic [7:0] exp, input string tag);
    sb_entry_t e;
    logic [7:0] obs;
    sb.push_back('{exp: exp, tag: tag});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = observed();
    inc_cnt += int'(obs[4]);
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
    end
    checks++;
    assert (!(obs[6] && obs[5]) && !(obs[4] && obs[3])) else begin
      errors++;
      $error("FAIL %s_excl: observed=%b expected=no rd&wr, no inc_pc&load_pc", e.tag, obs);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; opcode = LDA; zero = 1'b0;
    cyc(Z, "reset");
    cyc(Z, "reset_hold");

    // LDA: operand read in S4-S6, accumulator load only in S5.
    rst = 1'b0; ena = 1'b1; opcode = LDA;
    cyc(FETCH, "lda_s0"); cyc(FETCH, "lda_s1"); cyc(Z, "lda_s2"); cyc(Z, "lda_s3");
    cyc(RD, "lda_s4"); cyc(RDACC, "lda_s5"); cyc(RD, "lda_s6"); cyc(Z, "lda_s7");

    // STO: bus drive S4-S6, write only in S5, no reads after fetch.
    opcode = STO;
    cyc(FETCH, "sto_s0"); cyc(FETCH, "sto_s1"); cyc(Z, "sto_s2"); cyc(Z, "sto_s3");
    cyc(DE, "sto_s4"); cyc(WRDE, "sto_s5"); cyc(DE, "sto_s6"); cyc(Z, "sto_s7");

    // SKZ taken: four PC increments over the instruction.
    opcode = SKZ; zero = 1'b1; inc_cnt = 0;
    cyc(FETCH, "skz1_s0"); cyc(FETCH, "skz1_s1"); cyc(Z, "skz1_s2"); cyc(Z, "skz1_s3");
    cyc(Z, "skz1_s4"); cyc(INC, "skz1_s5"); cyc(Z, "skz1_s6"); cyc(INC, "skz1_s7");
    check_eq("skz1_pc_delta", inc_cnt, 4);

    // SKZ not taken: only the fetch increments.
    zero = 1'b0; inc_cnt = 0;
    cyc(FETCH, "skz0_s0"); cyc(FETCH, "skz0_s1"); cyc(Z, "skz0_s2"); cyc(Z, "skz0_s3");
    cyc(Z, "skz0_s4"); cyc(Z, "skz0_s5"); cyc(Z, "skz0_s6"); cyc(Z, "skz0_s7");
    check_eq("skz0_pc_delta", inc_cnt, 2);

    // JMP aborted in S5, then restarted from S0.
    opcode = JMP;
    cyc(FETCH, "jmp_s0"); cyc(FETCH, "jmp_s1"); cyc(Z, "jmp_s2"); cyc(Z, "jmp_s3");
    cyc(LPC, "jmp_s4"); cyc(LPC, "jmp_s5");
    ena = 1'b0;
    cyc(Z, "jmp_abort");
    cyc(Z, "jmp_idle");
    ena = 1'b1;
    cyc(FETCH, "restart_s0");

    // HLT: halt from S3 and sticky through ena toggling.
    opcode = HLT;
    cyc(FETCH, "hlt_s1"); cyc(Z, "hlt_s2"); cyc(HLTW, "hlt_s3"); cyc(HLTW, "hlt_halted");
    for (int i = 0; i < 20; i++) begin
      ena = ~ena;
      opcode = 3'($urandom_range(7, 0));
      cyc(HLTW, "halt_sticky");
    end

    // Reset overrides HALTED even with ena high.
    ena = 1'b1; rst = 1'b1;
    cyc(Z, "halt_rst");
    rst = 1'b0; ena = 1'b0; opcode = LDA;
    cyc(Z, "idle_after_rst");
    ena = 1'b1;
    cyc(FETCH, "post_rst_s0");

    // Reset mid-instruction takes priority over ena.
    cyc(FETCH, "mid_s1"); cyc(Z, "mid_s2"); cyc(Z, "mid_s3"); cyc(RD, "mid_s4");
    rst = 1'b1;
    cyc(Z, "mid_rst");
    rst = 1'b0;
    cyc(FETCH, "mid_restart_s0");

    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
